gabor_conv_sequencer: RTL

- Sequences one full 2D Gabor convolution pass over the pixel memory.
- Load phase: steers host pixel writes into the memory.
- Convolution phase: walks a KxK window over every valid interior centre, producing the memory read address, kernel ROM address and ALU tap strobes.
- Writes ALU results into the output RAM by centre index, then signals completion. Sits between the host interface and the memory / kernel ROM / ALU / output RAM datapath.

---
 rtl/gabor_pkg.sv | 26 ++
 rtl/gabor_window_addr_gen.sv | 72 +++++++
 rtl/gabor_conv_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/gabor_pkg.sv
// Shared geometry, derived counts and FSM encoding for the Gabor convolution sequencer.
// Purely declarative: no latency, no flow control.
package gabor_pkg;
   localparam int IMG_W = 16;
   localparam int IMG_H = 16;
   localparam int K     = 3;
   localparam int AW    = 8;
   localparam int OW    = 8;
   localparam int TW    = 4;
   localparam int M     = (K - 1) / 2;
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int NCX   = IMG_W - K + 1;
   localparam int NCY   = IMG_H - K + 1;
   localparam int NCENT = NCX * NCY;
   localparam int NTAPS = K * K;

   typedef logic [AW:0] addr_ext_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CONV,
      DRAIN,
      DONE
   } state_t;
endpackage

// File: rtl/gabor_window_addr_gen.sv
// Walks the KxK window over every interior centre, one tap per advance; address is combinational
// from the counters. Holds on the final tap until cleared, so it never wraps within a pass.
module gabor_window_addr_gen
   import gabor_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          advance,
   output logic [AW-1:0] read_address,
   output logic [TW-1:0] tap_idx,
   output logic          first_tap,
   output logic          last_tap,
   output logic          final_tap
);
   // Row/column counters hold the window's top-left corner, i.e. centre minus margin.
   addr_ext_t     ro_q, ro_d, co_q, co_d;
   logic [TW-1:0] kr_q, kr_d, kc_q, kc_d;
   logic          kc_end, kr_end, c_end, r_end;
   addr_ext_t     row_sum, col_sum, addr_ext;

   always_comb begin
      ro_d     = ro_q;
      co_d     = co_q;
      kr_d     = kr_q;
      kc_d     = kc_q;
      kc_end   = (kc_q == TW'(K - 1));
      kr_end   = (kr_q == TW'(K - 1));
      c_end    = (co_q == addr_ext_t'(NCX - 1));
      r_end    = (ro_q == addr_ext_t'(NCY - 1));
      first_tap = (kr_q == '0) && (kc_q == '0);
      last_tap  = kc_end && kr_end;
      final_tap = last_tap && c_end && r_end;
      if (advance && !final_tap) begin
         if (!kc_end) begin
            kc_d = kc_q + 1'b1;
         end else begin
            kc_d = '0;
            if (!kr_end) begin
               kr_d = kr_q + 1'b1;
            end else begin
               kr_d = '0;
               if (!c_end) begin
                  co_d = co_q + 1'b1;
               end else begin
                  co_d = '0;
                  ro_d = ro_q + 1'b1;
               end
            end
         end
      end
      row_sum      = ro_q + addr_ext_t'(kr_q);
      col_sum      = co_q + addr_ext_t'(kc_q);
      addr_ext     = row_sum * addr_ext_t'(IMG_W) + col_sum;
      read_address = addr_ext[AW-1:0];
      tap_idx      = kr_q * TW'(K) + kc_q;
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         ro_q <= '0;
         co_q <= '0;
         kr_q <= '0;
         kc_q <= '0;
      end else begin
         ro_q <= ro_d;
         co_q <= co_d;
         kr_q <= kr_d;
         kc_q <= kc_d;
      end
   end
endmodule

// File: rtl/gabor_conv_sequencer.sv
// Sequences load, KxK convolution issue and result write-back for one pass; tap strobes lag
// read_address by one cycle, DRAIN waits indefinitely for the ALU, done is a single-cycle pulse.
module gabor_conv_sequencer
   import gabor_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          conv,
   input  logic          wr_valid,
   output logic          mem_we,
   output logic [AW-1:0] write_address,
   output logic [AW-1:0] read_address,
   output logic [TW-1:0] kernel_addr,
   output logic          pixel_valid,
   output logic          acc_clear,
   output logic          last_tap,
   input  logic          result_valid,
   output logic          out_we,
   output logic [OW-1:0] out_addr,
   output logic          busy,
   output logic          done
);
   state_t        state_q, state_d;
   logic [AW:0]   wcnt_q, wcnt_d;
   logic [OW:0]   rcnt_q, rcnt_d;
   logic          pv_q, clr_q, last_q;
   logic [TW-1:0] kaddr_q;

   logic          issue, wr_acc, res_acc;
   logic [AW-1:0] gen_addr;
   logic [TW-1:0] gen_tap;
   logic          gen_first, gen_last, gen_final;

   gabor_window_addr_gen u_win (
      .clk          (clk),
      .reset        (reset),
      .clear        (!issue),
      .advance      (issue),
      .read_address (gen_addr),
      .tap_idx      (gen_tap),
      .first_tap    (gen_first),
      .last_tap     (gen_last),
      .final_tap    (gen_final)
   );

   assign issue   = (state_q == CONV);
   assign wr_acc  = (state_q == LOAD) && wr_valid;
   assign res_acc = ((state_q == CONV) || (state_q == DRAIN)) && result_valid &&
                    (rcnt_q < (OW+1)'(NCENT));

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      rcnt_d  = rcnt_q;
      case (state_q)
         IDLE: begin
            wcnt_d = '0;
            rcnt_d = '0;
            if (conv) state_d = LOAD;
         end
         LOAD: begin
            if (wr_acc) begin
               wcnt_d = wcnt_q + 1'b1;
               if (wcnt_q == (AW+1)'(NPIX - 1)) state_d = CONV;
            end
         end
         CONV:    if (gen_final) state_d = DRAIN;
         DRAIN:   state_d = DRAIN;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Results are counted in CONV as well, so completion may preempt the CONV->DRAIN move.
      if (res_acc) begin
         rcnt_d = rcnt_q + 1'b1;
         if (rcnt_q == (OW+1)'(NCENT - 1)) state_d = DONE;
      end
   end

   assign mem_we        = wr_acc;
   assign write_address = wr_acc ? wcnt_q[AW-1:0] : '0;
   assign read_address  = issue ? gen_addr : '0;
   assign out_we        = res_acc;
   assign out_addr      = res_acc ? rcnt_q[OW-1:0] : '0;
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);
   assign pixel_valid   = pv_q;
   assign kernel_addr   = kaddr_q;
   assign acc_clear     = clr_q;
   assign last_tap      = last_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         rcnt_q  <= '0;
         pv_q    <= 1'b0;
         kaddr_q <= '0;
         clr_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
         pv_q    <= issue;
         kaddr_q <= issue ? gen_tap : '0;
         clr_q   <= issue && gen_first;
         last_q  <= issue && gen_last;
      end
   end
endmodule
